// File: rtl/disp_src_ctrl_pkg.sv
// Shared definitions for the display source controller: source codes and timing defaults.
package disp_src_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_PC   = 2'b00,
    SRC_INST = 2'b01,
    SRC_ALU  = 2'b10,
    SRC_MEM  = 2'b11
  } src_e;

  localparam logic [19:0] DB_CNT_DEF   = 20'd250000;
  localparam logic [31:0] AUTO_CNT_DEF = 32'h003f_0000;

  // Source order wraps MEM -> PC through the natural 2-bit overflow.
  function automatic src_e next_src(input src_e s);
    return src_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on an accepted press.
module btn_debounce
  import disp_src_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_CNT = DB_CNT_DEF
) (
  input  logic clkIn,
  input  logic rst,
  input  logic btnIn,
  output logic pulse
);

  logic        sync1_q, sync2_q, stable_q;
  logic [19:0] cnt_q;
  logic        accept;

  always_comb begin
    accept = (sync2_q != stable_q) && (cnt_q == DB_CNT - 20'd1);
    // Pulse in the cycle the new level is accepted, rising edges only.
    pulse  = accept && sync2_q;
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btnIn;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

endmodule

// File: rtl/disp_src_ctrl.sv
// Selects, optionally freezes and half-selects a CPU debug value for the 7-segment driver.
module disp_src_ctrl
  import disp_src_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_CNT   = DB_CNT_DEF,
  parameter logic        AUTO_EN  = 1'b0,
  parameter logic [31:0] AUTO_CNT = AUTO_CNT_DEF
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        btnMode,
  input  logic        btnHalf,
  input  logic        btnHold,
  input  logic [31:0] pcIn,
  input  logic [31:0] instIn,
  input  logic [31:0] aluIn,
  input  logic [31:0] memIn,
  output logic [31:0] dispVal,
  output logic        dispHigh,
  output logic [1:0]  srcSel,
  output logic        holdLed
);

  logic mode_pulse, half_pulse, hold_pulse;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_mode (
    .clkIn (clkIn),
    .rst   (rst),
    .btnIn (btnMode),
    .pulse (mode_pulse)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_half (
    .clkIn (clkIn),
    .rst   (rst),
    .btnIn (btnHalf),
    .pulse (half_pulse)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_hold (
    .clkIn (clkIn),
    .rst   (rst),
    .btnIn (btnHold),
    .pulse (hold_pulse)
  );

  // Source FSM
  src_e src_q, src_d;

  always_ff @(posedge clkIn) begin
    if (rst) src_q <= SRC_PC;
    else     src_q <= src_d;
  end

  always_comb begin
    src_d = src_q;
    if (mode_pulse) src_d = next_src(src_q);
  end

  always_comb begin
    srcSel = src_q;
  end

  // Mux on the next source so a mode press shows the new source in the same update.
  logic [31:0] mux_val;

  always_comb begin
    mux_val = pcIn;
    unique case (src_d)
      SRC_PC:   mux_val = pcIn;
      SRC_INST: mux_val = instIn;
      SRC_ALU:  mux_val = aluIn;
      SRC_MEM:  mux_val = memIn;
    endcase
  end

  logic [31:0] disp_q, disp_d, auto_q, auto_d;
  logic        hold_q, hold_d, half_q, half_d, auto_exp;

  always_comb begin
    hold_d   = hold_q ^ hold_pulse;
    // The old hold state gates loading, so the entering cycle still captures a fresh value.
    disp_d   = (!hold_q || mode_pulse) ? mux_val : disp_q;
    auto_exp = AUTO_EN && (auto_q == AUTO_CNT - 32'd1);
    half_d   = half_q ^ (half_pulse || auto_exp);
    auto_d   = auto_q;
    if (half_pulse || auto_exp) auto_d = '0;
    else if (AUTO_EN)           auto_d = auto_q + 32'd1;
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      disp_q <= '0;
      hold_q <= 1'b0;
      half_q <= 1'b0;
      auto_q <= '0;
    end else begin
      disp_q <= disp_d;
      hold_q <= hold_d;
      half_q <= half_d;
      auto_q <= auto_d;
    end
  end

  assign dispVal  = disp_q;
  assign dispHigh = half_q;
  assign holdLed  = hold_q;

endmodule

// File: tb/tb_disp_src_ctrl.sv
// Directed bench for disp_src_ctrl: one auto-half instance and one manual-half instance.
module tb_disp_src_ctrl;

  logic        clkIn = 1'b0;
  logic        rst = 1'b0;
  logic        btnMode = 1'b0, btnHalf = 1'b0, btnHold = 1'b0;
  logic [31:0] pcIn = '0, instIn = '0, aluIn = '0, memIn = '0;
  logic [31:0] dispVal, dispVal_m;
  logic        dispHigh, dispHigh_m, holdLed, holdLed_m;
  logic [1:0]  srcSel, srcSel_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clkIn = ~clkIn;

  disp_src_ctrl #(.DB_CNT(20'd4), .AUTO_EN(1'b1), .AUTO_CNT(32'd8)) dut (
    .clkIn    (clkIn),
    .rst      (rst),
    .btnMode  (btnMode),
    .btnHalf  (btnHalf),
    .btnHold  (btnHold),
    .pcIn     (pcIn),
    .instIn   (instIn),
    .aluIn    (aluIn),
    .memIn    (memIn),
    .dispVal  (dispVal),
    .dispHigh (dispHigh),
    .srcSel   (srcSel),
    .holdLed  (holdLed)
  );

  disp_src_ctrl #(.DB_CNT(20'd4), .AUTO_EN(1'b0), .AUTO_CNT(32'd8)) dut_man (
    .clkIn    (clkIn),
    .rst      (rst),
    .btnMode  (btnMode),
    .btnHalf  (btnHalf),
    .btnHold  (btnHold),
    .pcIn     (pcIn),
    .instIn   (instIn),
    .aluIn    (aluIn),
    .memIn    (memIn),
    .dispVal  (dispVal_m),
    .dispHigh (dispHigh_m),
    .srcSel   (srcSel_m),
    .holdLed  (holdLed_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkIn);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // 0 = mode, 1 = half, 2 = hold; clean 10-cycle press then 10 idle cycles.
  task automatic press(input int which);
    case (which)
      0: btnMode = 1'b1;
      1: btnHalf = 1'b1;
      default: btnHold = 1'b1;
    endcase
    step(10);
    btnMode = 1'b0;
    btnHalf = 1'b0;
    btnHold = 1'b0;
    step(10);
  endtask

  initial begin
    step(1);
    // Reset values
    do_reset();
    check("rst_disp", dispVal, 32'h0);
    check("rst_high", 32'(dispHigh), 32'h0);
    check("rst_src", 32'(srcSel), 32'h0);
    check("rst_hold", 32'(holdLed), 32'h0);
    pcIn = 32'h0000_1234;
    step(1);
    check("pc_track", dispVal, 32'h0000_1234);

    // Mode cycling, with exact latency on the first press
    instIn = 32'h1111_0001;
    aluIn  = 32'h2222_0002;
    memIn  = 32'h3333_0003;
    btnMode = 1'b1;
    step(5);
    check("mode_early", 32'(srcSel), 32'h0);
    step(1);
    check("mode_inst", 32'(srcSel), 32'h1);
    check("disp_inst", dispVal, 32'h1111_0001);
    step(4);
    btnMode = 1'b0;
    step(10);
    press(0);
    check("mode_alu", 32'(srcSel), 32'h2);
    check("disp_alu", dispVal, 32'h2222_0002);
    aluIn = 32'h2222_00AA;
    step(1);
    check("alu_track", dispVal, 32'h2222_00AA);
    press(0);
    check("mode_mem", 32'(srcSel), 32'h3);
    check("disp_mem", dispVal, 32'h3333_0003);
    press(0);
    check("mode_wrap", 32'(srcSel), 32'h0);
    check("disp_pc", dispVal, 32'h0000_1234);

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      btnMode = ~btnMode;
      step(2);
    end
    btnMode = 1'b0;
    step(10);
    check("bounce_src", 32'(srcSel), 32'h0);

    // Hold
    press(0);
    press(0);
    check("hold_pre_src", 32'(srcSel), 32'h2);
    aluIn = 32'hDEAD_BEEF;
    step(1);
    btnHold = 1'b1;
    step(5);
    check("hold_early", 32'(holdLed), 32'h0);
    step(1);
    check("hold_on", 32'(holdLed), 32'h1);
    check("hold_val", dispVal, 32'hDEAD_BEEF);
    step(4);
    btnHold = 1'b0;
    step(10);
    aluIn = 32'h0;
    step(2);
    check("hold_frozen", dispVal, 32'hDEAD_BEEF);
    memIn = 32'hCAFE_F00D;
    btnMode = 1'b1;
    step(6);
    check("hold_mode_src", 32'(srcSel), 32'h3);
    check("hold_mode_cap", dispVal, 32'hCAFE_F00D);
    check("hold_still", 32'(holdLed), 32'h1);
    memIn = 32'h1111_2222;
    step(2);
    check("hold_refrozen", dispVal, 32'hCAFE_F00D);
    step(2);
    btnMode = 1'b0;
    step(10);
    press(2);
    check("hold_off", 32'(holdLed), 32'h0);
    check("hold_resume", dispVal, 32'h1111_2222);
    memIn = 32'h3333_4444;
    step(1);
    check("resume_track", dispVal, 32'h3333_4444);

    // Reset mid-operation, two cycles before a mode press is accepted
    press(0);
    press(0);
    press(0);
    press(2);
    check("mid_src", 32'(srcSel), 32'h2);
    check("mid_hold", 32'(holdLed), 32'h1);
    btnMode = 1'b1;
    step(4);
    rst = 1'b1;
    btnMode = 1'b0;
    step(1);
    check("mid_rst_disp", dispVal, 32'h0);
    check("mid_rst_src", 32'(srcSel), 32'h0);
    check("mid_rst_hold", 32'(holdLed), 32'h0);
    check("mid_rst_high", 32'(dispHigh), 32'h0);
    step(1);
    rst = 1'b0;
    step(12);
    check("post_rst_src", 32'(srcSel), 32'h0);
    check("post_rst_hold", 32'(holdLed), 32'h0);
    check("post_rst_disp", dispVal, 32'h0000_1234);

    // Auto half; R denotes the last reset edge
    do_reset();
    step(7);
    check("auto_r7", 32'(dispHigh), 32'h0);
    step(1);
    check("auto_r8", 32'(dispHigh), 32'h1);
    check("man_r8", 32'(dispHigh_m), 32'h0);
    step(8);
    check("auto_r16", 32'(dispHigh), 32'h0);
    step(2);
    btnHalf = 1'b1;
    step(5);
    check("auto_r23", 32'(dispHigh), 32'h0);
    check("man_r23", 32'(dispHigh_m), 32'h0);
    step(1);
    check("coincide_r24", 32'(dispHigh), 32'h1);
    check("man_r24", 32'(dispHigh_m), 32'h1);
    step(4);
    btnHalf = 1'b0;
    step(4);
    check("auto_r32", 32'(dispHigh), 32'h0);
    step(3);
    btnHalf = 1'b1;
    step(5);
    check("auto_r40", 32'(dispHigh), 32'h1);
    step(1);
    check("btn_r41", 32'(dispHigh), 32'h0);
    check("man_r41", 32'(dispHigh_m), 32'h0);
    step(7);
    check("restart_r48", 32'(dispHigh), 32'h0);
    step(1);
    check("restart_r49", 32'(dispHigh), 32'h1);
    btnHalf = 1'b0;
    step(10);
    check("man_final", 32'(dispHigh_m), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
